// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core
//   Time base and digit source for a 4-digit SS.hh stopwatch display (00.00..59.99).
//   A start/stop/clear state machine gates a prescaler that produces one tick per
//   hundredth of a second; each tick advances a 4-digit BCD cascade. A separate
//   free-running divider steps the 2-bit digit scan index for the display mux.
//
// Ports
//   clk              in   1  system clock, rising edge
//   reset            in   1  synchronous, active-high
//   start_stop       in   1  debounced one-cycle pulse, toggles run/pause
//   clear            in   1  debounced one-cycle pulse, zeroes the time
//   BCD0             out  4  hundredths units, 0..9
//   BCD1             out  4  tenths, 0..9
//   BCD2             out  4  seconds units, 0..9
//   BCD3             out  4  seconds tens, 0..5
//   refresh_counter  out  2  digit scan index, 0..3
//   running          out  1  high while in RUN
//   overflow         out  1  one-cycle pulse on the 59.99 -> 00.00 wrap
//
// Parameters
//   CLK_HZ / TICK_HZ gives the prescaler division (must be >= 2).
//   REFRESH_DIV is the number of clocks per scan step (must be >= 1).

module stopwatch_bcd_core #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic [1:0] refresh_counter,
  output logic       running,
  output logic       overflow
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e             state_q,   state_d;
  logic [PRE_W-1:0]   pre_q,     pre_d;
  logic [3:0]         d0_q,      d0_d;
  logic [3:0]         d1_q,      d1_d;
  logic [3:0]         d2_q,      d2_d;
  logic [3:0]         d3_q,      d3_d;
  logic               run_q,     run_d;
  logic               ovf_q,     ovf_d;
  logic [REF_W-1:0]   ref_div_q, ref_div_d;
  logic [1:0]         ref_cnt_q, ref_cnt_d;
  logic               tick;

  // Tick fires on the last prescaler count while running.
  assign tick = (state_q == ST_RUN) && (pre_q == PRE_MAX);

  // Run/pause/clear state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_stop) state_d = ST_RUN;
      ST_RUN:   if (start_stop) state_d = ST_PAUSE;
      ST_PAUSE: begin
        // start_stop takes priority over clear; clear alone returns to IDLE.
        if (start_stop)  state_d = ST_RUN;
        else if (clear)  state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Prescaler: counts only in RUN, holds in PAUSE so a partial tick resumes.
  always_comb begin
    pre_d = pre_q;
    if (clear)                 pre_d = '0;
    else if (tick)             pre_d = '0;
    else if (state_q == ST_RUN) pre_d = pre_q + 1'b1;
  end

  // BCD cascade: all digits resolve in one pass so no intermediate value is shown.
  // Clear takes precedence over a coincident tick, which also suppresses overflow.
  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    d2_d  = d2_q;
    d3_d  = d3_q;
    ovf_d = 1'b0;
    if (clear) begin
      d0_d = '0;
      d1_d = '0;
      d2_d = '0;
      d3_d = '0;
    end else if (tick) begin
      if (d0_q == 4'd9) begin
        d0_d = '0;
        if (d1_q == 4'd9) begin
          d1_d = '0;
          if (d2_q == 4'd9) begin
            d2_d = '0;
            if (d3_q == 4'd5) begin
              d3_d  = '0;
              ovf_d = 1'b1;
            end else begin
              d3_d = d3_q + 4'd1;
            end
          end else begin
            d2_d = d2_q + 4'd1;
          end
        end else begin
          d1_d = d1_q + 4'd1;
        end
      end else begin
        d0_d = d0_q + 4'd1;
      end
    end
  end

  assign run_d = (state_d == ST_RUN);

  // Display scan divider runs in every state and ignores start_stop/clear.
  always_comb begin
    ref_div_d = ref_div_q + 1'b1;
    ref_cnt_d = ref_cnt_q;
    if (ref_div_q == REF_MAX) begin
      ref_div_d = '0;
      ref_cnt_d = ref_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      run_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ref_div_q <= '0;
      ref_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      run_q     <= run_d;
      ovf_q     <= ovf_d;
      ref_div_q <= ref_div_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  assign BCD0            = d0_q;
  assign BCD1            = d1_q;
  assign BCD2            = d2_q;
  assign BCD3            = d3_q;
  assign refresh_counter = ref_cnt_q;
  assign running         = run_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Self-checking bench for stopwatch_bcd_core (TICK_DIV=10, REFRESH_DIV=4).
// Reference model tracks elapsed running clocks since the last clear and
// clocks since reset; expected digits and scan index are derived arithmetically.

module tb_stopwatch_bcd_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] BCD0, BCD1, BCD2, BCD3;
  logic [1:0] refresh_counter;
  logic       running;
  logic       overflow;

  always #5 clk = ~clk;

  stopwatch_bcd_core #(
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .REFRESH_DIV(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_stop     (start_stop),
    .clear          (clear),
    .BCD0           (BCD0),
    .BCD1           (BCD1),
    .BCD2           (BCD2),
    .BCD3           (BCD3),
    .refresh_counter(refresh_counter),
    .running        (running),
    .overflow       (overflow)
  );

  int total = 0;
  int bad   = 0;

  // Model: mode 0 stopped-at-zero, 1 running, 2 paused.
  int m_mode = 0;
  int m_rc   = 0;   // running clocks since clear, modulo 6000 hundredths * 10
  int m_cyc  = 0;   // clocks since reset
  bit m_ov   = 0;

  typedef struct {
    bit          ss;
    bit          clr;
    int          ncyc;
    logic [15:0] bcd;
    bit          run;
  } vec_t;

  vec_t tbl [25];

  function automatic logic [15:0] act_bcd();
    return {BCD3, BCD2, BCD1, BCD0};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_mode = 0; m_rc = 0; m_cyc = 0; m_ov = 0;
    end else begin
      m_ov = 0;
      if (clear) m_rc = 0;
      else if (m_mode == 1) begin
        m_rc++;
        if (m_rc == 60000) begin
          m_rc = 0;
          m_ov = 1;
        end
      end
      if (start_stop)                 m_mode = (m_mode == 1) ? 2 : 1;
      else if (clear && m_mode == 2)  m_mode = 0;
      m_cyc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    int hs;
    int exp;
    hs  = m_rc / 10;
    exp = ((hs / 1000) << 12) | (((hs / 100) % 10) << 8) | (((hs / 10) % 10) << 4) | (hs % 10);
    chk({tag, ".bcd"}, int'(act_bcd()), exp);
    chk({tag, ".running"}, int'(running), (m_mode == 1) ? 1 : 0);
    chk({tag, ".overflow"}, int'(overflow), int'(m_ov));
    chk({tag, ".refresh"}, int'(refresh_counter), (m_cyc / 4) % 4);
  endtask

  initial begin
    bit ov_seen;
    bit reached;

    tbl[0]  = '{0, 0, 50,    16'h0000, 0};
    tbl[1]  = '{1, 0, 1,     16'h0000, 1};
    tbl[2]  = '{0, 0, 9,     16'h0000, 1};
    tbl[3]  = '{0, 0, 1,     16'h0001, 1};
    tbl[4]  = '{0, 0, 990,   16'h0100, 1};
    tbl[5]  = '{0, 0, 4,     16'h0100, 1};
    tbl[6]  = '{1, 0, 1,     16'h0100, 0};
    tbl[7]  = '{0, 0, 20,    16'h0100, 0};
    tbl[8]  = '{1, 0, 1,     16'h0100, 1};
    tbl[9]  = '{0, 0, 4,     16'h0100, 1};
    tbl[10] = '{0, 0, 1,     16'h0101, 1};
    tbl[11] = '{0, 1, 1,     16'h0000, 1};
    tbl[12] = '{0, 0, 10,    16'h0001, 1};
    tbl[13] = '{0, 0, 12330, 16'h1234, 1};
    tbl[14] = '{1, 0, 1,     16'h1234, 0};
    tbl[15] = '{1, 1, 1,     16'h0000, 1};
    tbl[16] = '{0, 0, 10,    16'h0001, 1};
    tbl[17] = '{1, 0, 1,     16'h0001, 0};
    tbl[18] = '{0, 1, 1,     16'h0000, 0};
    tbl[19] = '{0, 0, 15,    16'h0000, 0};
    tbl[20] = '{0, 1, 1,     16'h0000, 0};
    tbl[21] = '{1, 0, 1,     16'h0000, 1};
    tbl[22] = '{0, 0, 99,    16'h0009, 1};
    tbl[23] = '{0, 1, 1,     16'h0000, 1};
    tbl[24] = '{0, 0, 10,    16'h0001, 1};

    // Reset held three cycles.
    reset = 1'b1;
    repeat (3) step();
    chk("rst.bcd", int'(act_bcd()), 0);
    chk("rst.refresh", int'(refresh_counter), 0);
    chk("rst.running", int'(running), 0);
    chk("rst.overflow", int'(overflow), 0);
    reset = 1'b0;

    // Idle scan: index advances every 4 clocks, digits stay at zero.
    for (int j = 1; j <= 16; j++) begin
      step();
      chk("scan.refresh", int'(refresh_counter), (j / 4) % 4);
    end
    chk("scan.bcd", int'(act_bcd()), 0);

    // Table: pulse on the first cycle of each entry, then idle cycles.
    for (int i = 0; i < 25; i++) begin
      start_stop = tbl[i].ss;
      clear      = tbl[i].clr;
      step();
      start_stop = 1'b0;
      clear      = 1'b0;
      for (int k = 1; k < tbl[i].ncyc; k++) step();
      chk($sformatf("vec%0d.bcd", i), int'(act_bcd()), int'(tbl[i].bcd));
      chk($sformatf("vec%0d.running", i), int'(running), int'(tbl[i].run));
      chk($sformatf("vec%0d.overflow", i), int'(overflow), 0);
    end
    check_model("post_table");

    // Run up to 59.99, then one more tick wraps with a single overflow pulse.
    ov_seen = 0;
    reached = 0;
    for (int n = 0; n < 70000 && !reached; n++) begin
      step();
      if (overflow) ov_seen = 1;
      if (act_bcd() == 16'h5999) reached = 1;
    end
    chk("wrap.reached_5999", int'(reached), 1);
    chk("wrap.no_early_overflow", int'(ov_seen), 0);
    repeat (9) step();
    chk("wrap.hold_5999", int'(act_bcd()), 16'h5999);
    chk("wrap.pre_overflow", int'(overflow), 0);
    step();
    chk("wrap.bcd", int'(act_bcd()), 0);
    chk("wrap.overflow", int'(overflow), 1);
    chk("wrap.running", int'(running), 1);
    step();
    chk("wrap.overflow_drop", int'(overflow), 0);
    chk("wrap.running_after", int'(running), 1);
    check_model("post_wrap");

    // Reset asserted mid-run.
    repeat (27) step();
    reset = 1'b1;
    step();
    chk("midrst.bcd", int'(act_bcd()), 0);
    chk("midrst.running", int'(running), 0);
    chk("midrst.refresh", int'(refresh_counter), 0);
    chk("midrst.overflow", int'(overflow), 0);
    reset = 1'b0;

    // Randomized pulses against the reference model.
    for (int n = 0; n < 3000; n++) begin
      start_stop = ($urandom_range(0, 39) == 0);
      clear      = ($urandom_range(0, 59) == 0);
      reset      = ($urandom_range(0, 999) == 0);
      step();
      check_model("rand");
    end
    start_stop = 1'b0;
    clear      = 1'b0;
    reset      = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
